// File: rtl/vector_sequencer_if.sv
// Bundle of command, line-generator and DAC signals for vector_sequencer.
// Build option: none. The VSEQ_DWELL_EN macro affects only vector_sequencer.
//
// Port summary (all signals bundled; clk/reset stay module ports):
//   command  : cmd_valid, cmd_ready, cmd_jump, cmd_x, cmd_y, cmd_z
//   line gen : line_start, line_x0/y0/x1/y1, line_pt_valid, line_px/py,
//              line_last, line_next
//   DAC      : dac_value, dac_channel, dac_strobe, dac_ready
//   status   : blank, busy
//
// Modports:
//   master : the sequencer. Accepts commands and drives the line-generator
//            and DAC control signals.
//   slave  : the surroundings (display-list fetcher, line generator, DAC).
interface vector_sequencer_if #(
   parameter int unsigned COORD_W = 12,
   parameter int unsigned Z_W     = 8
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_jump;
   logic [COORD_W-1:0] cmd_x;
   logic [COORD_W-1:0] cmd_y;
   logic [Z_W-1:0]     cmd_z;

   logic               line_start;
   logic [COORD_W-1:0] line_x0;
   logic [COORD_W-1:0] line_y0;
   logic [COORD_W-1:0] line_x1;
   logic [COORD_W-1:0] line_y1;
   logic               line_pt_valid;
   logic [COORD_W-1:0] line_px;
   logic [COORD_W-1:0] line_py;
   logic               line_last;
   logic               line_next;

   logic [COORD_W-1:0] dac_value;
   logic [1:0]         dac_channel;
   logic               dac_strobe;
   logic               dac_ready;

   logic               blank;
   logic               busy;

   modport master (
      input  cmd_valid, cmd_jump, cmd_x, cmd_y, cmd_z,
      output cmd_ready,
      output line_start, line_x0, line_y0, line_x1, line_y1, line_next,
      input  line_pt_valid, line_px, line_py, line_last,
      output dac_value, dac_channel, dac_strobe,
      input  dac_ready,
      output blank, busy
   );

   modport slave (
      output cmd_valid, cmd_jump, cmd_x, cmd_y, cmd_z,
      input  cmd_ready,
      input  line_start, line_x0, line_y0, line_x1, line_y1, line_next,
      output line_pt_valid, line_px, line_py, line_last,
      input  dac_value, dac_channel, dac_strobe,
      output dac_ready,
      input  blank, busy
   );
endinterface

// File: rtl/vector_sequencer.sv
// Vector display command sequencer. Takes jump/draw commands and steps the beam
// through the line generator and the X/Y/Z DAC, handling blanking, post-jump
// settle, intensity writes and zero-length draws.
//
// Build option: define VSEQ_DWELL_EN to add a beam-on dwell of DWELL_CYCLES
// clocks at the end of every draw. Without it, draws finish straight to IDLE.
//
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high
//   bus    : vector_sequencer_if.master (command in, line gen, DAC, status)
//
// dac_strobe, line_start and line_next are decoded from state and dac_ready so
// a strobe never fires while the DAC is busy and the line generator advances on
// the same edge the sequencer leaves LY. All other outputs are registered.
module vector_sequencer #(
   parameter int unsigned COORD_W       = 12,
   parameter int unsigned Z_W           = 8,
   parameter int unsigned SETTLE_CYCLES = 64,
   parameter int unsigned DWELL_CYCLES  = 16
) (
   input  logic                clk,
   input  logic                reset,
   vector_sequencer_if.master  bus
);

   localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam int unsigned PAD_W   = COORD_W - Z_W;

   typedef enum logic [3:0] {
      IDLE, JX, JY, SETTLE, DZ, LWAIT, LX, LY
`ifdef VSEQ_DWELL_EN
      , DWELL
`endif
   } state_t;

`ifdef VSEQ_DWELL_EN
   localparam state_t DRAW_END = (DWELL_CYCLES == 0) ? IDLE : DWELL;
`else
   localparam state_t DRAW_END = IDLE;
`endif

   state_t             state, state_nxt;
   logic [COORD_W-1:0] tgt_x, tgt_y, cur_x, cur_y, pt_y;
   logic               pt_last;
   logic [CNT_W-1:0]   cnt;
   logic [COORD_W-1:0] dac_value_q, x0_q, y0_q, x1_q, y1_q;
   logic [1:0]         dac_channel_q;
   logic               blank_q, cmd_ready_q, busy_q;
   logic               zero_len, beam_on_nxt;
   logic               dac_strobe_c, line_start_c, line_next_c;

   assign zero_len = (tgt_x == cur_x) && (tgt_y == cur_y);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.cmd_valid) state_nxt = bus.cmd_jump ? JX : DZ;
         JX:      if (bus.dac_ready) state_nxt = JY;
         JY:      if (bus.dac_ready) state_nxt = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
         SETTLE:  if (cnt == '0) state_nxt = IDLE;
         DZ:      if (bus.dac_ready) state_nxt = zero_len ? DRAW_END : LWAIT;
         LWAIT:   if (bus.line_pt_valid) state_nxt = LX;
         LX:      if (bus.dac_ready) state_nxt = LY;
         LY:      if (bus.dac_ready) state_nxt = pt_last ? DRAW_END : LWAIT;
`ifdef VSEQ_DWELL_EN
         DWELL:   if (cnt == '0) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: handshake pulses and the beam state for the next cycle
   always_comb begin
      dac_strobe_c = 1'b0;
      line_start_c = 1'b0;
      line_next_c  = 1'b0;
      beam_on_nxt  = 1'b0;
      case (state)
         JX, JY, LX: dac_strobe_c = bus.dac_ready;
         DZ: begin
            dac_strobe_c = bus.dac_ready;
            line_start_c = bus.dac_ready && !zero_len;
         end
         LY: begin
            dac_strobe_c = bus.dac_ready;
            line_next_c  = bus.dac_ready;
         end
         default: ;
      endcase
      case (state_nxt)
         LWAIT, LX, LY: beam_on_nxt = 1'b1;
`ifdef VSEQ_DWELL_EN
         DWELL:         beam_on_nxt = 1'b1;
`endif
         default:       beam_on_nxt = 1'b0;
      endcase
   end

   // Datapath and registered outputs. Each DAC word is loaded on the edge that
   // enters its write state, so it is stable for the whole write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tgt_x         <= '0;
         tgt_y         <= '0;
         cur_x         <= '0;
         cur_y         <= '0;
         pt_y          <= '0;
         pt_last       <= 1'b0;
         cnt           <= '0;
         dac_value_q   <= '0;
         dac_channel_q <= 2'd0;
         x0_q          <= '0;
         y0_q          <= '0;
         x1_q          <= '0;
         y1_q          <= '0;
         blank_q       <= 1'b1;
         cmd_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         blank_q     <= !beam_on_nxt;
         cmd_ready_q <= (state_nxt == IDLE);
         busy_q      <= (state_nxt != IDLE);

         // Wait counter: preloaded outside the wait states, counts down inside
         case (state)
            SETTLE: cnt <= cnt - CNT_W'(1);
`ifdef VSEQ_DWELL_EN
            DWELL:  cnt <= cnt - CNT_W'(1);
            default: cnt <= (state_nxt == DWELL) ? CNT_W'(DWELL_CYCLES - 1) : CNT_W'(SETTLE_CYCLES - 1);
`else
            default: cnt <= CNT_W'(SETTLE_CYCLES - 1);
`endif
         endcase

         case (state)
            IDLE: if (bus.cmd_valid) begin
               tgt_x <= bus.cmd_x;
               tgt_y <= bus.cmd_y;
               if (bus.cmd_jump) begin
                  dac_value_q   <= bus.cmd_x;
                  dac_channel_q <= 2'd0;
               end else begin
                  dac_value_q   <= COORD_W'(bus.cmd_z) << PAD_W;
                  dac_channel_q <= 2'd2;
                  x0_q          <= cur_x;
                  y0_q          <= cur_y;
                  x1_q          <= bus.cmd_x;
                  y1_q          <= bus.cmd_y;
               end
            end
            JX: if (bus.dac_ready) begin
               dac_value_q   <= tgt_y;
               dac_channel_q <= 2'd1;
            end
            JY: if (bus.dac_ready) begin
               cur_x <= tgt_x;
               cur_y <= tgt_y;
            end
            LWAIT: if (bus.line_pt_valid) begin
               dac_value_q   <= bus.line_px;
               dac_channel_q <= 2'd0;
               pt_y          <= bus.line_py;
               pt_last       <= bus.line_last;
            end
            LX: if (bus.dac_ready) begin
               dac_value_q   <= pt_y;
               dac_channel_q <= 2'd1;
            end
            LY: if (bus.dac_ready && pt_last) begin
               cur_x <= tgt_x;
               cur_y <= tgt_y;
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.busy        = busy_q;
   assign bus.blank       = blank_q;
   assign bus.dac_value   = dac_value_q;
   assign bus.dac_channel = dac_channel_q;
   assign bus.dac_strobe  = dac_strobe_c;
   assign bus.line_start  = line_start_c;
   assign bus.line_next   = line_next_c;
   assign bus.line_x0     = x0_q;
   assign bus.line_y0     = y0_q;
   assign bus.line_x1     = x1_q;
   assign bus.line_y1     = y1_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: jump with settle, a four-point draw with
// a DAC stall, a zero-length draw and a reset in the middle of a draw.
// Dwell expectations follow the VSEQ_DWELL_EN build option.
module tb_vector_sequencer;

   localparam int unsigned COORD_W = 12;
   localparam int unsigned Z_W     = 8;
   localparam int unsigned SETTLE  = 4;
   localparam int unsigned DWELL   = 16;
`ifdef VSEQ_DWELL_EN
   localparam int DWELL_EXP = 16;
`else
   localparam int DWELL_EXP = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   vector_sequencer_if #(.COORD_W(COORD_W), .Z_W(Z_W)) bus ();

   vector_sequencer #(
      .COORD_W(COORD_W), .Z_W(Z_W), .SETTLE_CYCLES(SETTLE), .DWELL_CYCLES(DWELL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      int nexts;

      reset             = 1'b1;
      bus.cmd_valid     = 1'b0;
      bus.cmd_jump      = 1'b0;
      bus.cmd_x         = '0;
      bus.cmd_y         = '0;
      bus.cmd_z         = '0;
      bus.line_pt_valid = 1'b0;
      bus.line_px       = '0;
      bus.line_py       = '0;
      bus.line_last     = 1'b0;
      bus.dac_ready     = 1'b1;
      tick();
      tick();

      // Reset state
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_blank", 32'(bus.blank), 32'd1);
      chk("rst_dac_value", 32'(bus.dac_value), 32'd0);
      chk("rst_dac_channel", 32'(bus.dac_channel), 32'd0);
      chk("rst_dac_strobe", 32'(bus.dac_strobe), 32'd0);
      chk("rst_line_start", 32'(bus.line_start), 32'd0);
      chk("rst_line_next", 32'(bus.line_next), 32'd0);
      chk("rst_line_x1", 32'(bus.line_x1), 32'd0);
      reset = 1'b0;
      tick();

      // Jump to (100,200); command inputs are scrambled after acceptance
      bus.cmd_valid = 1'b1;
      bus.cmd_jump  = 1'b1;
      bus.cmd_x     = 12'd100;
      bus.cmd_y     = 12'd200;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_x     = 12'd999;
      bus.cmd_y     = 12'd999;
      #1;
      chk("jx_strobe", 32'(bus.dac_strobe), 32'd1);
      chk("jx_channel", 32'(bus.dac_channel), 32'd0);
      chk("jx_value", 32'(bus.dac_value), 32'd100);
      chk("jx_blank", 32'(bus.blank), 32'd1);
      chk("jx_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      tick();
      chk("jy_strobe", 32'(bus.dac_strobe), 32'd1);
      chk("jy_channel", 32'(bus.dac_channel), 32'd1);
      chk("jy_value", 32'(bus.dac_value), 32'd200);
      n = 1;
      while (bus.cmd_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
         chk("settle_blank", 32'(bus.blank), 32'd1);
         chk("settle_strobe", 32'(bus.dac_strobe), 32'd0);
      end
      chk("jump_latency", 32'(n), 32'd6);

      // Draw to (103,200) at full intensity
      bus.cmd_valid = 1'b1;
      bus.cmd_jump  = 1'b0;
      bus.cmd_x     = 12'd103;
      bus.cmd_y     = 12'd200;
      bus.cmd_z     = 8'hFF;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_x     = 12'd0;
      #1;
      chk("dz_strobe", 32'(bus.dac_strobe), 32'd1);
      chk("dz_channel", 32'(bus.dac_channel), 32'd2);
      chk("dz_value", 32'(bus.dac_value), 32'hFF0);
      chk("dz_line_start", 32'(bus.line_start), 32'd1);
      chk("dz_x0", 32'(bus.line_x0), 32'd100);
      chk("dz_y0", 32'(bus.line_y0), 32'd200);
      chk("dz_x1", 32'(bus.line_x1), 32'd103);
      chk("dz_y1", 32'(bus.line_y1), 32'd200);
      tick();
      chk("lwait_blank", 32'(bus.blank), 32'd0);
      chk("lwait_line_start", 32'(bus.line_start), 32'd0);
      chk("lwait_busy", 32'(bus.busy), 32'd1);

      nexts = 0;
      for (int i = 0; i < 4; i++) begin
         bus.line_pt_valid = 1'b1;
         bus.line_px       = 12'(100 + i);
         bus.line_py       = 12'd200;
         bus.line_last     = (i == 3);
         if (i == 1) bus.dac_ready = 1'b0;
         tick();
         if (i == 1) begin
            for (int k = 0; k < 10; k++) begin
               chk("stall_strobe", 32'(bus.dac_strobe), 32'd0);
               chk("stall_value", 32'(bus.dac_value), 32'd101);
               if (k < 9) tick();
            end
            bus.dac_ready = 1'b1;
            #1;
         end
         chk("lx_strobe", 32'(bus.dac_strobe), 32'd1);
         chk("lx_channel", 32'(bus.dac_channel), 32'd0);
         chk("lx_value", 32'(bus.dac_value), 32'(100 + i));
         chk("lx_blank", 32'(bus.blank), 32'd0);
         tick();
         chk("ly_strobe", 32'(bus.dac_strobe), 32'd1);
         chk("ly_channel", 32'(bus.dac_channel), 32'd1);
         chk("ly_value", 32'(bus.dac_value), 32'd200);
         chk("ly_blank", 32'(bus.blank), 32'd0);
         if (bus.line_next === 1'b1) nexts++;
         tick();
      end
      bus.line_pt_valid = 1'b0;
      bus.line_last     = 1'b0;
      chk("line_next_count", 32'(nexts), 32'd4);
      n = 0;
      while (bus.blank === 1'b0 && n < 40) begin
         n++;
         tick();
      end
      chk("draw_dwell_cycles", 32'(n), 32'(DWELL_EXP));
      chk("draw_done_ready", 32'(bus.cmd_ready), 32'd1);

      // Zero-length draw to the current point (103,200)
      bus.cmd_valid = 1'b1;
      bus.cmd_jump  = 1'b0;
      bus.cmd_x     = 12'd103;
      bus.cmd_y     = 12'd200;
      bus.cmd_z     = 8'h12;
      tick();
      bus.cmd_valid = 1'b0;
      #1;
      chk("zl_strobe", 32'(bus.dac_strobe), 32'd1);
      chk("zl_value", 32'(bus.dac_value), 32'h120);
      chk("zl_line_start", 32'(bus.line_start), 32'd0);
      chk("zl_x0", 32'(bus.line_x0), 32'd103);
      chk("zl_y0", 32'(bus.line_y0), 32'd200);
      tick();
      n = 0;
      while (bus.blank === 1'b0 && n < 40) begin
         chk("zl_no_line_start", 32'(bus.line_start), 32'd0);
         n++;
         tick();
      end
      chk("zl_dwell_cycles", 32'(n), 32'(DWELL_EXP));
      chk("zl_ready", 32'(bus.cmd_ready), 32'd1);

      // Draw to (110,210), then reset while waiting for the first point
      bus.cmd_valid = 1'b1;
      bus.cmd_x     = 12'd110;
      bus.cmd_y     = 12'd210;
      bus.cmd_z     = 8'h80;
      tick();
      bus.cmd_valid = 1'b0;
      #1;
      chk("rd_line_start", 32'(bus.line_start), 32'd1);
      tick();
      chk("rd_busy", 32'(bus.busy), 32'd1);
      chk("rd_blank", 32'(bus.blank), 32'd0);
      reset = 1'b1;
      #1;
      chk("mid_rst_blank", 32'(bus.blank), 32'd1);
      chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_dac_value", 32'(bus.dac_value), 32'd0);
      chk("mid_rst_dac_channel", 32'(bus.dac_channel), 32'd0);
      chk("mid_rst_strobe", 32'(bus.dac_strobe), 32'd0);
      chk("mid_rst_line_x0", 32'(bus.line_x0), 32'd0);
      chk("mid_rst_line_x1", 32'(bus.line_x1), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Jump accepted after the abort
      bus.cmd_valid = 1'b1;
      bus.cmd_jump  = 1'b1;
      bus.cmd_x     = 12'd5;
      bus.cmd_y     = 12'd6;
      tick();
      bus.cmd_valid = 1'b0;
      #1;
      chk("post_rst_strobe", 32'(bus.dac_strobe), 32'd1);
      chk("post_rst_value", 32'(bus.dac_value), 32'd5);
      chk("post_rst_channel", 32'(bus.dac_channel), 32'd0);
      tick();
      chk("post_rst_y_value", 32'(bus.dac_value), 32'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
